button_conditioner: RTL and testbench

Multi-channel input conditioner for the Tug of War player buttons. Each raw push input passes through an N-stage synchronizer and a per-channel debounce counter, producing a clean level plus one-cycle press and release pulses. A tie flag marks presses that land on the same clock. Game logic consumes these outputs instead of raw or single-flop-synchronized buttons.

---
 rtl/button_conditioner.sv | 63 ++++++
 tb/tb_button_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Tug of War button front end: synchronize, debounce, and edge-detect each
// player input, flagging presses that land on the same clock.
module button_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] push_raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                simul
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CW-1:0]          cnt    [CHANNELS];
    logic [CHANNELS-1:0]    sync;
    logic [CHANNELS-1:0]    flip;
    logic [CHANNELS-1:0]    rise;

    // A channel flips on the edge that completes a full run of mismatches.
    always_comb begin
        sync = '0;
        flip = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sync[i] = sync_q[i][SYNC_STAGES-1];
            flip[i] = (sync[i] != level[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign rise = flip & ~level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
                cnt[i]    <= '0;
            end
            level         <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            simul         <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], push_raw[i]};
                if (sync[i] == level[i] || flip[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + 1'b1;
            end
            level         <= level ^ flip;
            press_pulse   <= rise;
            release_pulse <= flip & level;
            simul         <= ($countones(rise) > 1);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bounce
// traffic against a windowed reference model.
module tb_button_conditioner;

    localparam int CH   = 2;
    localparam int S    = 2;
    localparam int D    = 4;
    localparam int HMAX = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] push_raw = '0;
    logic [CH-1:0] level;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic          simul;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .CHANNELS(CH),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .push_raw(push_raw),
        .level(level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .simul(simul)
    );

    always #5 clk = ~clk;

    // Reference: level flips once the last D synchronized samples all
    // disagree with it and all fall after the previous flip (or reset).
    logic [CH-1:0] raw_hist [HMAX];
    int            e = 0;
    int            last_flip [CH];
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_press = '0;
    logic [CH-1:0] m_rel   = '0;
    logic          m_simul = 1'b0;
    bit            m_flip;

    function automatic logic sync_at(int t, int c);
        if (t - S >= 1) return raw_hist[t-S][c];
        return 1'b0;
    endfunction

    initial begin
        for (int c = 0; c < CH; c++) last_flip[c] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                e = 0;
                m_level = '0;
                m_press = '0;
                m_rel   = '0;
                m_simul = 1'b0;
                for (int c = 0; c < CH; c++) last_flip[c] = 0;
            end else begin
                e++;
                if (e < HMAX) raw_hist[e] = push_raw;
                m_press = '0;
                m_rel   = '0;
                for (int c = 0; c < CH; c++) begin
                    m_flip = (e - last_flip[c] >= D);
                    for (int j = 0; j < D; j++)
                        if (sync_at(e - j, c) == m_level[c]) m_flip = 1'b0;
                    if (m_flip) begin
                        if (m_level[c]) m_rel[c] = 1'b1;
                        else m_press[c] = 1'b1;
                        m_level[c] = ~m_level[c];
                        last_flip[c] = e;
                    end
                end
                m_simul = ($countones(m_press) >= 2);
            end
        end
    end

    function automatic logic [6:0] obs();
        return {level, press_pulse, release_pulse, simul};
    endfunction

    function automatic logic [6:0] mexp();
        return {m_level, m_press, m_rel, m_simul};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        push_raw = 2'b11;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs(), 7'd0);
        end
        push_raw = 2'b01;
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== mexp()) begin
                n_fail++;
                $display("FAIL reset_model k%0d: got %b expected %b",
                         k, obs(), mexp());
            end
            n_checks++;
            if ({level[0], press_pulse[0], simul} !== {k >= 6, k == 6, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold k%0d: got %b expected %b", k,
                         {level[0], press_pulse[0], simul},
                         {k >= 6, k == 6, 1'b0});
            end
        end
    endtask

    task automatic test_glitch();
        push_raw = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level[1], press_pulse[1], release_pulse[1]} !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch3 k%0d: got %b expected 000", k,
                         {level[1], press_pulse[1], release_pulse[1]});
            end
            if (k == 3) push_raw = 2'b01;
        end
        push_raw = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level[1], press_pulse[1], release_pulse[1]} !==
                {k >= 6 && k < 10, k == 6, k == 10}) begin
                n_fail++;
                $display("FAIL glitch4 k%0d: got %b expected %b", k,
                         {level[1], press_pulse[1], release_pulse[1]},
                         {k >= 6 && k < 10, k == 6, k == 10});
            end
            n_checks++;
            if (obs() !== mexp()) begin
                n_fail++;
                $display("FAIL glitch_model k%0d: got %b expected %b",
                         k, obs(), mexp());
            end
            if (k == 4) push_raw = 2'b01;
        end
    endtask

    task automatic test_release();
        push_raw = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level[0], press_pulse[0], release_pulse[0]} !==
                {k < 6, 1'b0, k == 6}) begin
                n_fail++;
                $display("FAIL release k%0d: got %b expected %b", k,
                         {level[0], press_pulse[0], release_pulse[0]},
                         {k < 6, 1'b0, k == 6});
            end
        end
    endtask

    task automatic test_tie();
        push_raw = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if ({press_pulse, simul} !== {(k == 6) ? 2'b11 : 2'b00, k == 6}) begin
                n_fail++;
                $display("FAIL tie k%0d: got %b expected %b", k,
                         {press_pulse, simul},
                         {(k == 6) ? 2'b11 : 2'b00, k == 6});
            end
        end
        push_raw = 2'b00;
        repeat (10) @(negedge clk);
        push_raw = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) push_raw = 2'b11;
            n_checks++;
            if ({press_pulse, simul} !== {k == 7, k == 6, 1'b0}) begin
                n_fail++;
                $display("FAIL stagger k%0d: got %b expected %b", k,
                         {press_pulse, simul}, {k == 7, k == 6, 1'b0});
            end
        end
        push_raw = 2'b00;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_bounce();
        push_raw = 2'b01;
        @(negedge clk);
        push_raw = 2'b00;
        @(negedge clk);
        push_raw = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level[0], press_pulse[0]} !== {k >= 6, k == 6}) begin
                n_fail++;
                $display("FAIL bounce k%0d: got %b expected %b", k,
                         {level[0], press_pulse[0]}, {k >= 6, k == 6});
            end
        end
        push_raw = 2'b00;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        push_raw = 2'b01;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs() !== 7'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b expected %b", obs(), 7'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            n_checks++;
            if ({level[0], press_pulse[0]} !== {k >= 6, k == 6}) begin
                n_fail++;
                $display("FAIL mid_requal k%0d: got %b expected %b", k,
                         {level[0], press_pulse[0]}, {k >= 6, k == 6});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== mexp()) begin
                n_fail++;
                $display("FAIL random k%0d: got %b expected %b",
                         k, obs(), mexp());
            end
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 149) == 0) rst = 1'b1;
            if ($urandom_range(0, 3) == 0) push_raw = CH'($urandom);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_release();
        test_tie();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
